// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: request codes, shifter commands, FSM states.
package shift_seq_pkg;

    localparam int N_W_DEF     = 5;
    localparam int LUI_AMT_DEF = 16;

    localparam logic [2:0] REQ_SLL  = 3'd0;
    localparam logic [2:0] REQ_SRL  = 3'd1;
    localparam logic [2:0] REQ_SRA  = 3'd2;
    localparam logic [2:0] REQ_PASS = 3'd3;
    localparam logic [2:0] REQ_LUI  = 3'd4;

    localparam logic [2:0] SH_NOP  = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_LEFT = 3'b010;
    localparam logic [2:0] SH_RLOG = 3'b011;
    localparam logic [2:0] SH_RARI = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // PASS and the illegal codes map to SH_NOP, which the FSM treats as "skip SHIFT".
    function automatic logic [2:0] op_to_cmd(input logic [2:0] op);
        case (op)
            REQ_SLL: op_to_cmd = SH_LEFT;
            REQ_SRL: op_to_cmd = SH_RLOG;
            REQ_SRA: op_to_cmd = SH_RARI;
            REQ_LUI: op_to_cmd = SH_LEFT;
            default: op_to_cmd = SH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/shift_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter; on a conflict the requester that did not win last time is granted.
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic enable,
    output logic grant0,
    output logic grant1
);

    logic last_grant;

    always_comb begin
        grant0 = enable && valid0 && (!valid1 || last_grant);
        grant1 = enable && valid1 && (!valid0 || !last_grant);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Sequences the shared shifter through LOAD then SHIFT for two arbitrated requesters.
//   state | meaning
//   IDLE  | waiting; accepts one request per cycle
//   LOAD  | shifter loads operand, src_sel chosen
//   SHIFT | shifter applies latched command and amount
//   DONE  | result valid, done pulse with owner id
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int N_W     = N_W_DEF,
    parameter int LUI_AMT = LUI_AMT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0_valid,
    input  logic [2:0]     req0_op,
    input  logic [N_W-1:0] req0_shamt,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [2:0]     req1_op,
    input  logic [N_W-1:0] req1_shamt,
    output logic           req1_ready,
    output logic [2:0]     shift_ctrl,
    output logic [N_W-1:0] shift_n,
    output logic           src_sel,
    output logic           busy,
    output logic           done,
    output logic           done_id
);

    state_t         state, state_nxt;
    logic [2:0]     cmd_q, cmd_nxt;
    logic [N_W-1:0] amt_q, amt_nxt;
    logic           skip_q, skip_nxt;
    logic           owner_q, owner_nxt;
    logic [2:0]     ctrl_nxt;
    logic [N_W-1:0] n_nxt;
    logic           src_nxt;
    logic           grant0, grant1;
    logic [2:0]     sel_op;
    logic [N_W-1:0] sel_shamt;
    logic           sel_lui;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .enable ((state == ST_IDLE) && !reset),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign done_id    = done & owner_q;

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        amt_nxt   = amt_q;
        skip_nxt  = skip_q;
        owner_nxt = owner_q;
        ctrl_nxt  = SH_NOP;
        n_nxt     = shift_n;
        src_nxt   = src_sel;
        sel_op    = grant1 ? req1_op : req0_op;
        sel_shamt = grant1 ? req1_shamt : req0_shamt;
        sel_lui   = (sel_op == REQ_LUI);

        case (state)
            ST_IDLE: begin
                if (grant0 || grant1) begin
                    state_nxt = ST_LOAD;
                    ctrl_nxt  = SH_LOAD;
                    src_nxt   = sel_lui;
                    owner_nxt = grant1;
                    cmd_nxt   = op_to_cmd(sel_op);
                    amt_nxt   = sel_lui ? N_W'(LUI_AMT) : sel_shamt;
                    skip_nxt  = (op_to_cmd(sel_op) == SH_NOP) ||
                                (!sel_lui && (sel_shamt == '0));
                end
            end
            ST_LOAD: begin
                if (skip_q) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_SHIFT;
                    ctrl_nxt  = cmd_q;
                    n_nxt     = amt_q;
                end
            end
            ST_SHIFT: state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cmd_q      <= SH_NOP;
            amt_q      <= '0;
            skip_q     <= 1'b0;
            owner_q    <= 1'b0;
            shift_ctrl <= SH_NOP;
            shift_n    <= '0;
            src_sel    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cmd_q      <= cmd_nxt;
            amt_q      <= amt_nxt;
            skip_q     <= skip_nxt;
            owner_q    <= owner_nxt;
            shift_ctrl <= ctrl_nxt;
            shift_n    <= n_nxt;
            src_sel    <= src_nxt;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: single ops, SHIFT skipping, round robin, reset abort.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [2:0] req0_op, req1_op;
    logic [4:0] req0_shamt, req1_shamt;
    logic       req0_ready, req1_ready;
    logic [2:0] shift_ctrl;
    logic [4:0] shift_n;
    logic       src_sel, busy, done, done_id;

    int n_checks = 0;
    int n_pass   = 0;
    int rari_seen = 0;

    shift_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_shamt (req0_shamt),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_shamt (req1_shamt),
        .req1_ready (req1_ready),
        .shift_ctrl (shift_ctrl),
        .shift_n    (shift_n),
        .src_sel    (src_sel),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (shift_ctrl == 3'b100) rari_seen++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request from an idle sequencer, checked through to the return to IDLE.
    task automatic run_single(input bit port, input logic [2:0] op, input logic [4:0] shamt,
                              input logic [2:0] exp_cmd, input logic [4:0] exp_n,
                              input bit exp_src, input bit exp_skip);
        if (port) begin
            req1_valid = 1; req1_op = op; req1_shamt = shamt;
        end else begin
            req0_valid = 1; req0_op = op; req0_shamt = shamt;
        end
        #1;
        check("accept_ready0", req0_ready, !port);
        check("accept_ready1", req1_ready, port);
        tick();
        req0_valid = 0; req1_valid = 0;
        check("load_ctrl", shift_ctrl, 3'b001);
        check("load_src", src_sel, exp_src);
        check("load_busy", busy, 1);
        check("load_ready", req0_ready | req1_ready, 0);
        if (!exp_skip) begin
            tick();
            check("shift_ctrl", shift_ctrl, exp_cmd);
            check("shift_n", shift_n, exp_n);
            check("shift_done", done, 0);
        end
        tick();
        check("done", done, 1);
        check("done_id", done_id, port);
        check("done_ctrl", shift_ctrl, 3'b000);
        check("done_busy", busy, 1);
        tick();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("src_hold", src_sel, exp_src);
    endtask

    initial begin
        reset = 1;
        req0_valid = 1; req0_op = 3'd0; req0_shamt = 5'd4;
        req1_valid = 1; req1_op = 3'd0; req1_shamt = 5'd0;
        tick(); tick();
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_ctrl", shift_ctrl, 0);
        check("rst_n", shift_n, 0);
        check("rst_src", src_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_id", done_id, 0);
        req0_valid = 0; req1_valid = 0;
        reset = 0;
        tick();

        // SLL 4 from port 0, then LUI (shamt ignored) from port 1
        run_single(0, 3'd0, 5'd4, 3'b010, 5'd4, 0, 0);
        run_single(1, 3'd4, 5'd7, 3'b010, 5'd16, 1, 0);

        // SRA by 0 and PASS both skip SHIFT; no arithmetic shift may be issued
        rari_seen = 0;
        run_single(0, 3'd2, 5'd0, 3'b100, 5'd0, 0, 1);
        run_single(1, 3'd3, 5'd9, 3'b000, 5'd0, 0, 1);
        check("no_rari", rari_seen, 0);

        // Both held valid: last grant was port 1, so grants go 0,1,0,1 every 4 cycles
        req0_valid = 1; req0_op = 3'd0; req0_shamt = 5'd1;
        req1_valid = 1; req1_op = 3'd1; req1_shamt = 5'd2;
        for (int g = 0; g < 4; g++) begin
            #1;
            check("rr_ready0", req0_ready, (g % 2) == 0);
            check("rr_ready1", req1_ready, (g % 2) == 1);
            tick();
            check("rr_busy_ready", req0_ready | req1_ready, 0);
            tick();
            check("rr_shift_n", shift_n, (g % 2) ? 5'd2 : 5'd1);
            tick();
            check("rr_done", done, 1);
            check("rr_done_id", done_id, g % 2);
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        tick();

        // Reset during SHIFT of SRL 31 from port 0
        req0_valid = 1; req0_op = 3'd1; req0_shamt = 5'd31;
        #1;
        check("srl_ready0", req0_ready, 1);
        tick();
        req0_valid = 0;
        tick();
        check("srl_ctrl", shift_ctrl, 3'b011);
        check("srl_n", shift_n, 5'd31);
        reset = 1;
        req0_valid = 1; req0_op = 3'd3; req0_shamt = 5'd0;
        req1_valid = 1; req1_op = 3'd3; req1_shamt = 5'd0;
        #1;
        check("rstmid_ready", req0_ready | req1_ready, 0);
        tick();
        check("rstmid_busy", busy, 0);
        check("rstmid_ctrl", shift_ctrl, 0);
        check("rstmid_done", done, 0);
        reset = 0;
        #1;
        check("post_rst_ready0", req0_ready, 1);
        check("post_rst_ready1", req1_ready, 0);
        tick();
        req0_valid = 0; req1_valid = 0;
        tick();
        check("post_rst_done", done, 1);
        check("post_rst_done_id", done_id, 0);
        tick();

        // Illegal op 6 behaves as PASS: busy for exactly LOAD and DONE
        run_single(0, 3'd6, 5'd5, 3'b000, 5'd0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle sequencer and arbiter for the shared 32-bit shift register used by ALU-class operations.
- Accepts shift requests from two requesters: port 0 is the main control FSM (SLL/SRL/SRA/SLLV/SRLV/SRAV); port 1 is the auxiliary path (LUI, pass-through).
- Drives the shifter's LOAD-then-SHIFT command sequence, source mux and shift amount.
- Signals completion with the winning requester id so the result is sampled exactly once.

Parameters:
- N_W, 5, shift-amount width (shifter N input).
- LUI_AMT, 16, fixed left-shift amount for LUI requests.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has a pending request
- req0_op  in  3  requester 0 operation code (package REQ_*)
- req0_shamt  in  5  requester 0 shift amount
- req0_ready  out  1  combinational; request 0 accepted this cycle
- req1_valid  in  1  requester 1 has a pending request
- req1_op  in  3  requester 1 operation code
- req1_shamt  in  5  requester 1 shift amount
- req1_ready  out  1  combinational; request 1 accepted this cycle
- shift_ctrl  out  3  shifter command (package SH_*), registered
- shift_n  out  5  shifter amount, registered
- src_sel  out  1  shifter data mux: 0 = register operand, 1 = immediate/LUI source; registered
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse; shifter output is valid this cycle
- done_id  out  1  requester that owns the current done

Behaviour:
- Request codes:
  - REQ_SLL = 0, REQ_SRL = 1, REQ_SRA = 2, REQ_PASS = 3, REQ_LUI = 4.
  - Codes 5-7 are illegal: accepted, then treated as REQ_PASS.
- Shifter commands: SH_NOP = 000, SH_LOAD = 001, SH_LEFT = 010, SH_RLOG = 011, SH_RARI = 100.
- States:
  - IDLE: shift_ctrl = SH_NOP.
  - LOAD: shift_ctrl = SH_LOAD; src_sel = 1 if op is LUI, else 0.
  - SHIFT: shift_ctrl = op command; shift_n = latched amount.
  - DONE: shift_ctrl = SH_NOP; done = 1; done_id = owner.
  - DONE always returns to IDLE.
- Accept and arbitration (IDLE only):
  - If any req_valid is high, one request is granted and its readyN is asserted for that cycle.
  - op, shamt and id are latched; next state is LOAD.
  - No request is accepted in any other state; ready = 0 outside IDLE.
- Round robin:
  - last_grant register, reset value 1, so req0 wins the first conflict.
  - On simultaneous valid, grant the requester != last_grant. A single valid requester always wins.
- LUI forces the latched amount to LUI_AMT and the command to SH_LEFT; the requester's shamt is ignored.
- SHIFT is skipped (LOAD goes directly to DONE) when the op is PASS, or when the latched amount is 0 and the op is not LUI.
- Latency from the accept edge to done:
  - 3 cycles normally.
  - 2 cycles when SHIFT is skipped.
- Throughput: the next accept is possible in the cycle after DONE (IDLE). Back-to-back requests therefore spaced 4 cycles, or 3 when SHIFT is skipped.
- shift_n holds its value outside SHIFT. src_sel holds from LOAD until the next LOAD.
- Reset value of all outputs:
  - shift_ctrl = 000, shift_n = 0, src_sel = 0.
  - busy = 0, done = 0, done_id = 0.
  - ready = 0 in the cycle reset is high.
- Reset mid-operation: return to IDLE on the next edge, with no done pulse and the in-flight request dropped. last_grant returns to 1.
- Requesters must hold valid/op/shamt until ready. Deasserting valid before ready withdraws the request with no side effects.

Decomposition:
- Package shift_seq_pkg holds:
  - REQ_* and SH_* localparams.
  - State encoding: IDLE, LOAD, SHIFT, DONE.
  - LUI_AMT default.
- Sub-module rr_arbiter2: the 2-way round-robin with last_grant. Inputs: valid0, valid1, enable (state==IDLE). Outputs: grant0, grant1.
- Everything else is a single FSM in shift_sequencer.

Test Plan:
- Reset, then req0 SLL with shamt 4 → ready0 in the accept cycle.
  - Next cycle: LOAD, src_sel = 0.
  - Then SH_LEFT with n = 4.
  - Then done = 1, done_id = 0, 3 cycles after accept.
- req1 LUI with shamt 7 → LOAD with src_sel = 1, then SH_LEFT n = 16, then done_id = 1.
- req0 SRA shamt 0 and req1 PASS, issued separately → each skips SHIFT, done 2 cycles after accept, no SH_RARI ever issued.
- req0 and req1 both held valid continuously → grants alternate 0, 1, 0, 1; each done_id matches its grant; accepts are 4 cycles apart.
- Assert reset during SHIFT of an SRL n = 31 → next cycle IDLE, shift_ctrl = 000, no done pulse. Then simultaneous requests → req0 wins.
- req0 op = 6 (illegal) → behaves as PASS: LOAD then DONE, done_id = 0; busy high for exactly 2 cycles.
